// File: rtl/param_bus_datapath.sv
// Single-bus register-file datapath with a three-step sequencer (Rb->Y, ALU->Z, Z->Ra or HI/LO).
// Define PARAM_BUS_DATAPATH_MULDIV_EN to build the signed multiply (op 11) and divide (op 12).
module param_bus_datapath #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] rc,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              zero,
    output logic              bad_op
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHRA = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_NEG  = 4'd9;
    localparam logic [3:0] OP_NOT  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_Y    = 2'd1,
        S_Z    = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [DATA_W-1:0]   r_y;
    logic [2*DATA_W-1:0] r_z;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [3:0]          r_op;
    logic [ADDR_W-1:0]   r_ra;
    logic [ADDR_W-1:0]   r_rb;
    logic [ADDR_W-1:0]   r_rc;
    logic                r_busy;
    logic                r_done;
    logic                r_zero;
    logic                r_bad;

    logic [DATA_W-1:0]   w_bus;
    logic [SH_W-1:0]     w_sh;
    logic [2*DATA_W-1:0] w_dbl;
    logic [DATA_W-1:0]   w_ror;
    logic [DATA_W-1:0]   w_rol;
    logic [DATA_W-1:0]   w_res_lo;
    logic [DATA_W-1:0]   w_res_hi;
    logic [2*DATA_W-1:0] w_alu;
    logic                w_bad;

    // The single shared bus carries Rb in T_Y and Rc otherwise (only consumed in T_Z)
    assign w_bus = (r_state == S_Y) ? r_regs[r_rb] : r_regs[r_rc];
    assign w_sh  = w_bus[SH_W-1:0];
    assign w_dbl = {r_y, r_y};
    assign w_ror = DATA_W'(w_dbl >> w_sh);
    assign w_rol = DATA_W'((w_dbl << w_sh) >> DATA_W);

`ifdef PARAM_BUS_DATAPATH_MULDIV_EN
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_divisor;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;

    assign w_prod    = $signed({{DATA_W{r_y[DATA_W-1]}}, r_y}) *
                       $signed({{DATA_W{w_bus[DATA_W-1]}}, w_bus});
    // Divisor forced non-zero so the divider never sees 0; the b==0 result is muxed in below
    assign w_divisor = (w_bus == '0) ? DATA_W'(1) : w_bus;
    assign w_quot    = $signed(r_y) / $signed(w_divisor);
    assign w_rem     = $signed(r_y) % $signed(w_divisor);
`endif

    always_comb begin
        w_res_lo = '0;
        w_res_hi = '0;
        w_bad    = 1'b0;
        case (r_op)
            OP_ADD:  w_res_lo = r_y + w_bus;
            OP_SUB:  w_res_lo = r_y - w_bus;
            OP_AND:  w_res_lo = r_y & w_bus;
            OP_OR:   w_res_lo = r_y | w_bus;
            OP_SHR:  w_res_lo = r_y >> w_sh;
            OP_SHRA: w_res_lo = DATA_W'($signed(r_y) >>> w_sh);
            OP_SHL:  w_res_lo = r_y << w_sh;
            OP_ROR:  w_res_lo = w_ror;
            OP_ROL:  w_res_lo = w_rol;
            OP_NEG:  w_res_lo = -w_bus;
            OP_NOT:  w_res_lo = ~w_bus;
`ifdef PARAM_BUS_DATAPATH_MULDIV_EN
            OP_MUL:  {w_res_hi, w_res_lo} = w_prod;
            OP_DIV: begin
                if (w_bus == '0) begin
                    w_res_lo = '1;
                    w_res_hi = r_y;
                end else begin
                    w_res_lo = w_quot;
                    w_res_hi = w_rem;
                end
            end
`endif
            default: w_bad = 1'b1;
        endcase
    end

    assign w_alu = {w_res_hi, w_res_lo};

    // Sequencer, register file and result registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_y    <= '0;
            r_z    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_op   <= '0;
            r_ra   <= '0;
            r_rb   <= '0;
            r_rc   <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_zero <= 1'b0;
            r_bad  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ext_we) begin
                        r_regs[ext_addr] <= ext_data;
                    end
                    if (start) begin
                        r_op    <= op;
                        r_ra    <= ra;
                        r_rb    <= rb;
                        r_rc    <= rc;
                        r_busy  <= 1'b1;
                        r_state <= S_Y;
                    end
                end
                S_Y: begin
                    r_y     <= w_bus;
                    r_state <= S_Z;
                end
                S_Z: begin
                    r_z     <= w_alu;
                    r_zero  <= (w_res_lo == '0);
                    r_bad   <= w_bad;
                    r_state <= S_WB;
                end
                S_WB: begin
                    if (!r_bad) begin
                        if (r_op == OP_MUL || r_op == OP_DIV) begin
                            r_hi <= r_z[2*DATA_W-1:DATA_W];
                            r_lo <= r_z[DATA_W-1:0];
                        end else begin
                            r_regs[r_ra] <= r_z[DATA_W-1:0];
                        end
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_data = r_regs[rd_addr];
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign busy    = r_busy;
    assign done    = r_done;
    assign zero    = r_zero;
    assign bad_op  = r_bad;

endmodule

// File: tb/tb_param_bus_datapath.sv
// Self-checking bench for param_bus_datapath: opcode vector table through a scoreboard plus
// hand-written sequences for reset-mid-op, ext load with start, and back-to-back issue.
module tb_param_bus_datapath;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 4;
    localparam logic [31:0] SENT = 32'hDEADBEEF;
`ifdef PARAM_BUS_DATAPATH_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    op = '0;
    logic [AW-1:0] ra = '0, rb = '0, rc = '0;
    logic          ext_we = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic [W-1:0]  ext_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_data, hi, lo;
    logic          busy, done, zero, bad_op;

    param_bus_datapath #(.DATA_W(W), .NUM_REGS(16)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op),
        .ra(ra), .rb(rb), .rc(rc),
        .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .zero(zero), .bad_op(bad_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        bit          bad;
        bit          hilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.r = r;
        v.bad = 1'b0; v.hilo = 1'b0; v.hi = '0; v.lo = '0;
        return v;
    endfunction

    function automatic vec_t mk_bad(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v = mk(o, a, b, SENT);
        v.bad = 1'b1;
        return v;
    endfunction

    // MUL/DIV vectors degrade to reserved-op expectations when the feature is compiled out
    function automatic vec_t mk_md(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] h, input logic [31:0] l);
        vec_t v;
        v = mk(o, a, b, SENT);
        if (MD) begin
            v.hilo = 1'b1; v.hi = h; v.lo = l;
        end else begin
            v.bad = 1'b1;
        end
        return v;
    endfunction

    function automatic logic exp_zero(input vec_t v);
        if (v.bad) return 1'b1;
        if (v.hilo) return (v.lo == '0);
        return (v.r == '0);
    endfunction

    task automatic ext_load(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        ext_we = 1'b1; ext_addr = a; ext_data = d;
        @(negedge clk);
        ext_we = 1'b0;
    endtask

    task automatic read_reg(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
        rd_addr = a;
        #1;
        check(name, rd_data, exp);
    endtask

    // Caller has driven start at a negedge; counts negedges until done (bounded)
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            ext_we = 1'b0;
            cnt++;
        end while (!done && cnt < 12);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   cnt;
        vec_t e;
        ext_load(4'd2, v.a);
        ext_load(4'd3, v.b);
        ext_load(4'd4, SENT);
        start = 1'b1; op = v.op; ra = 4'd4; rb = 4'd2; rc = 4'd3;
        sb.push_back(v);
        wait_done(cnt);
        check($sformatf("v%0d_latency", idx), 32'(cnt), 32'd4);
        if (sb.size() == 0) begin
            check($sformatf("v%0d_sb_empty", idx), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            if (e.hilo) begin
                m_hi = e.hi;
                m_lo = e.lo;
            end
            check($sformatf("v%0d_done", idx), 32'(done), 32'd1);
            check($sformatf("v%0d_bad_op", idx), 32'(bad_op), 32'(e.bad));
            check($sformatf("v%0d_zero", idx), 32'(zero), 32'(exp_zero(e)));
            check($sformatf("v%0d_hi", idx), hi, m_hi);
            check($sformatf("v%0d_lo", idx), lo, m_lo);
            read_reg($sformatf("v%0d_r4", idx), 4'd4, e.r);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cnt;
        bit  done_seen;

        vecs.push_back(mk(4'd0,  32'd5,        32'd7,        32'd12));
        vecs.push_back(mk(4'd1,  32'd5,        32'd7,        32'hFFFFFFFE));
        vecs.push_back(mk(4'd1,  32'd7,        32'd7,        32'd0));
        vecs.push_back(mk(4'd2,  32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F));
        vecs.push_back(mk(4'd3,  32'hF0000000, 32'h0000000F, 32'hF000000F));
        vecs.push_back(mk(4'd4,  32'h80000000, 32'd4,        32'h08000000));
        vecs.push_back(mk(4'd5,  32'h80000000, 32'd4,        32'hF8000000));
        vecs.push_back(mk(4'd5,  32'h40000000, 32'd4,        32'h04000000));
        vecs.push_back(mk(4'd6,  32'h00000001, 32'd31,       32'h80000000));
        vecs.push_back(mk(4'd6,  32'h00000001, 32'd33,       32'h00000002));
        vecs.push_back(mk(4'd7,  32'h00000001, 32'd1,        32'h80000000));
        vecs.push_back(mk(4'd8,  32'h80000000, 32'd36,       32'h00000008));
        vecs.push_back(mk(4'd9,  32'd123,      32'd1,        32'hFFFFFFFF));
        vecs.push_back(mk(4'd10, 32'd123,      32'h0000FFFF, 32'hFFFF0000));
        vecs.push_back(mk_md(4'd11, 32'hFFFFFFFA, 32'd4,      32'hFFFFFFFF, 32'hFFFFFFE8));
        vecs.push_back(mk_md(4'd11, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000));
        vecs.push_back(mk(4'd0,  32'd1,        32'd2,        32'd3));
        vecs.push_back(mk_md(4'd12, 32'hFFFFFFF9, 32'd2,      32'hFFFFFFFF, 32'hFFFFFFFD));
        vecs.push_back(mk_md(4'd12, 32'hFFFFFFF9, 32'd0,      32'hFFFFFFF9, 32'hFFFFFFFF));
        vecs.push_back(mk_md(4'd12, 32'd7,     32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD));
        vecs.push_back(mk_bad(4'd13, 32'd5,    32'd7));
        vecs.push_back(mk_bad(4'd14, 32'd5,    32'd7));
        vecs.push_back(mk_bad(4'd15, 32'd5,    32'd7));

        // Reset state
        repeat (2) @(negedge clk);
        clr = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_bad_op", 32'(bad_op), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        read_reg("rst_r0", 4'd0, 32'd0);
        read_reg("rst_r15", 4'd15, 32'd0);

        // Reset in the middle of T_Z of ADD R1,R2,R3
        ext_load(4'd1, 32'h11);
        ext_load(4'd2, 32'd5);
        ext_load(4'd3, 32'd7);
        start = 1'b1; op = 4'd0; ra = 4'd1; rb = 4'd2; rc = 4'd3;
        @(negedge clk);
        start = 1'b0;
        check("clr_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("clr_busy_async", 32'(busy), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        done_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("clr_no_done", 32'(done_seen), 32'd0);
        check("clr_busy_after", 32'(busy), 32'd0);
        read_reg("clr_r1", 4'd1, 32'd0);
        read_reg("clr_r2", 4'd2, 32'd0);
        read_reg("clr_r3", 4'd3, 32'd0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // External load committed in the same IDLE cycle as start is seen by the op
        ext_load(4'd2, 32'd1);
        ext_load(4'd3, 32'd50);
        ext_we = 1'b1; ext_addr = 4'd3; ext_data = 32'd100;
        start = 1'b1; op = 4'd0; ra = 4'd6; rb = 4'd2; rc = 4'd3;
        wait_done(cnt);
        check("extstart_latency", 32'(cnt), 32'd4);
        read_reg("extstart_r6", 4'd6, 32'd101);

        // Back-to-back: SUB R1,R1,R1 then ADD R5,R1,R2 with start held; busy-time inputs ignored
        ext_load(4'd1, 32'd9);
        ext_load(4'd2, 32'h55);
        start = 1'b1; op = 4'd1; ra = 4'd1; rb = 4'd1; rc = 4'd1;
        @(negedge clk);
        op = 4'd0; ra = 4'd5; rb = 4'd1; rc = 4'd2;
        ext_we = 1'b1; ext_addr = 4'd2; ext_data = 32'hBAD;
        check("b2b_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        ext_we = 1'b0;
        @(negedge clk);
        check("b2b_done1", 32'(done), 32'd1);
        read_reg("b2b_r1", 4'd1, 32'd0);
        @(negedge clk);
        check("b2b_busy2", 32'(busy), 32'd1);
        check("b2b_done_low", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("b2b_done2", 32'(done), 32'd1);
        start = 1'b0;
        read_reg("b2b_r5", 4'd5, 32'h55);
        read_reg("b2b_r2_kept", 4'd2, 32'h55);
        @(negedge clk);
        check("b2b_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
